// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Handshake: start is sampled only while idle (busy=0); once accepted, busy
// stays high for exactly WIDTH cycles, then done pulses for one cycle together
// with fresh digitos/overflow/blank. Those outputs hold until the next done.
// A start seen while busy is dropped, not queued.
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      entrada,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   digitos,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank,
   output logic                  state_dbg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
   localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  sreg, sreg_shift;
   logic [BW-1:0]     acc, adj, acc_shift;
   logic              ovf_flag, ovf_shift;
   logic [CW-1:0]     cnt;
   logic              last_bit;
   logic [BW-1:0]     res_dig;
   logic [DIGITS-1:0] res_blank;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: leave IDLE on start, leave CONV after the last shift.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = CONV;
         CONV:    if (last_bit) state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
   always_comb begin
      adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      acc_shift  = {adj[BW-2:0], sreg[WIDTH-1]};
      sreg_shift = sreg << 1;
      // A carry out of the top digit means the value needs more digits.
      ovf_shift  = ovf_flag | adj[BW-1];
      last_bit   = (cnt == CW'(1));
   end

   // Result formatting: saturate to all nines on overflow, then mark leading zeros.
   always_comb begin
      logic run;
      run       = 1'b1;
      res_dig   = ovf_shift ? {DIGITS{4'h9}} : acc_shift;
      res_blank = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run          = run & (res_dig[4*i +: 4] == 4'd0);
         res_blank[i] = run;
      end
   end

   // Conversion datapath: capture on accepted start, shift once per CONV cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg     <= '0;
         acc      <= '0;
         ovf_flag <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sreg     <= entrada;
                  acc      <= '0;
                  ovf_flag <= 1'b0;
                  cnt      <= CNT_LOAD;
               end
            end
            CONV: begin
               sreg     <= sreg_shift;
               acc      <= acc_shift;
               ovf_flag <= ovf_shift;
               cnt      <= cnt - CW'(1);
            end
            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   // Output registers: updated only on the edge performing the final shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done     <= 1'b0;
         digitos  <= '0;
         overflow <= 1'b0;
         blank    <= BLANK_RST;
      end else begin
         done <= 1'b0;
         if (state == CONV && last_bit) begin
            done     <= 1'b1;
            digitos  <= res_dig;
            overflow <= ovf_shift;
            blank    <= res_blank;
         end
      end
   end

   assign busy      = (state == CONV);
   assign state_dbg = state;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Parametrised sequential binary-to-BCD converter for the seven-segment display path. It generalises the fixed 4-bit, two-digit combinational converter to any input width and digit count, using an iterative shift-add-3 (double-dabble) engine that processes one input bit per clock. It adds a start/busy/done handshake, saturating overflow detection and a leading-zero blanking mask. Its outputs feed the display multiplexer directly.

## Interface
- WIDTH, 8: binary input width; legal range 1..32.
- DIGITS, 3: number of BCD output digits; legal range 1..10.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- entrada  input  WIDTH  unsigned binary value; captured on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digitos/overflow/blank values are valid.
- digitos  output  4*DIGITS  BCD result; digit i occupies bits [4i+3:4i], digit 0 = units.
- overflow  output  1  result did not fit in DIGITS digits.
- blank  output  DIGITS  bit i high means display digit i is a leading zero.

## Operation
- States: IDLE, CONV.
- IDLE: start=1 at an edge → capture entrada into the shift register, clear the internal BCD accumulator (4*DIGITS bits), clear the sticky overflow flag, load bit counter = WIDTH, go to CONV.
- CONV, every cycle: for each digit ≥ 5, add 3 (4-bit result); then shift {accumulator, shift register} left by one. The MSB of the shift register enters accumulator bit 0. A bit shifted out of accumulator bit 4*DIGITS-1 ORs into the overflow flag. Decrement the counter.
- On the edge that performs the final (WIDTH-th) shift:
  - Register the outputs: digitos = accumulator, or all 4'h9 if overflow; overflow = flag.
  - Register blank: bit i = 1 when digit i and all higher digits of the registered digitos are zero; bit 0 is always 0.
  - Assert done for one cycle and return to IDLE.
- digitos, overflow and blank hold their values until the next done. They never change mid-conversion.
- start while busy is ignored, with no queuing. entrada changes after capture have no effect.
- Overflow is exact: prefix values grow monotonically, so any carry out of the top digit implies entrada ≥ 10^DIGITS.

## Timing
- Reset values: state IDLE, busy 0, done 0, digitos 0, overflow 0, blank = {DIGITS-1 ones, 0}.
- Start accepted at edge k: busy=1 in cycles following edges k..k+WIDTH-1. At edge k+WIDTH, busy falls, done rises and the outputs update.
- Latency from accepting edge to done: WIDTH cycles.
- Start is not accepted on the edge where done rises, because the block is still in CONV there. The earliest next accept is edge k+WIDTH+1. Throughput: one conversion per WIDTH+1 cycles.
- Holding start high continuously gives back-to-back conversions at that rate.
- Reset asserted mid-conversion: abort immediately to reset values; done is not produced.
- WIDTH=1: single CONV cycle; digitos = entrada.

## Test plan
- WIDTH=4, DIGITS=2, entrada=13, start pulse at edge 0 → done at edge 4; digitos=8'h13, overflow=0, blank=2'b00; busy high exactly 4 cycles.
- WIDTH=8, DIGITS=3: entrada=255 → digitos=12'h255. entrada=0 → digitos=12'h000, blank=3'b110. entrada=7 → blank=3'b110. entrada=40 → blank=3'b100.
- WIDTH=8, DIGITS=2: entrada=99 → 8'h99, overflow=0. entrada=100 → 8'h99, overflow=1. entrada=200 → 8'h99, overflow=1.
- Start re-pulsed mid-conversion with a different entrada → ignored; first result unchanged; exactly one done. Start held high → done every 9 cycles for WIDTH=8.
- Reset asserted at cycle 3 of a WIDTH=8 conversion → busy, done and outputs at reset values immediately; no done afterwards. A fresh start then converts correctly.
- Exhaustive sweep for WIDTH=4/DIGITS=2 and WIDTH=10/DIGITS=3, compared against a reference model:
  - digitos, overflow and blank match for every input.
  - Outputs are stable between done pulses.
